// File: rtl/rvfi_commit_sched.sv
// rvfi_commit_sched: dual-lane retirement to single-lane RVFI commit scheduler.
// Buffers up to two in-order commit records per cycle and emits one record per
// cycle with a running 64-bit retirement order, plus sticky halt/error flags.
module rvfi_commit_sched #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned PKT_W = 311
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              in_valid,
   input  logic [PKT_W-1:0]        in_pkt0,
   input  logic [PKT_W-1:0]        in_pkt1,
   output logic                    in_ready,
   output logic                    out_valid,
   output logic [63:0]             out_order,
   output logic [PKT_W-1:0]        out_pkt,
   output logic [$clog2(DEPTH):0]  occupancy,
   output logic                    halt,
   output logic                    error
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;

   // Highest occupancy that still leaves room for a full lane pair.
   localparam logic [PTR_W-1:0] OCC_MAX_ACCEPT = PTR_W'(DEPTH - 2);

   // Record field positions used by halt detection.
   localparam int unsigned INST_LSB     = 279;
   localparam int unsigned PC_RDATA_LSB = 136;
   localparam int unsigned PC_WDATA_LSB = 104;

   // Self-branch / self-jump encodings that the core uses to park itself.
   localparam logic [31:0] INST_BEQ_SELF = 32'h0000_0063;
   localparam logic [31:0] INST_JAL_SELF = 32'h0000_006f;

   // Storage (contents are not reset; validity is tracked by the pointers).
   logic [PKT_W-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [63:0]      order_q, order_d;
   logic             out_valid_q, out_valid_d;
   logic [63:0]      out_order_q, out_order_d;
   logic [PKT_W-1:0] out_pkt_q, out_pkt_d;
   logic             halt_q, halt_d;
   logic             error_q, error_d;

   logic [PTR_W-1:0] occ_c;
   logic             ready_c;
   logic             push0_c;
   logic             push1_c;
   logic             pop_c;
   logic             reject_c;
   logic             halt_hit_c;
   logic [IDX_W-1:0] wr_idx0_c;
   logic [IDX_W-1:0] wr_idx1_c;
   logic [IDX_W-1:0] rd_idx_c;
   logic [31:0]      out_inst_c;
   logic [31:0]      out_pc_rdata_c;
   logic [31:0]      out_pc_wdata_c;

   // Acceptance, rejection and pointer arithmetic from registered state.
   always_comb begin
      occ_c     = wr_ptr_q - rd_ptr_q;
      ready_c   = !halt_q && (occ_c <= OCC_MAX_ACCEPT);
      // Lane0 alone or both lanes; lane1 alone never writes.
      push0_c   = ready_c && in_valid[0];
      push1_c   = ready_c && (in_valid == 2'b11);
      reject_c  = (in_valid == 2'b10) || ((in_valid != 2'b00) && !ready_c);
      pop_c     = (occ_c != '0);
      wr_idx0_c = wr_ptr_q[IDX_W-1:0];
      wr_idx1_c = wr_ptr_q[IDX_W-1:0] + IDX_W'(1);
      rd_idx_c  = rd_ptr_q[IDX_W-1:0];
   end

   // Halt decode on the record currently held in the output register.
   always_comb begin
      out_inst_c     = out_pkt_q[INST_LSB +: 32];
      out_pc_rdata_c = out_pkt_q[PC_RDATA_LSB +: 32];
      out_pc_wdata_c = out_pkt_q[PC_WDATA_LSB +: 32];
      halt_hit_c     = out_valid_q &&
                       ((out_pc_rdata_c == out_pc_wdata_c) ||
                        (out_inst_c == INST_BEQ_SELF) ||
                        (out_inst_c == INST_JAL_SELF));
   end

   // Next-state: pointers, order counter, output register and sticky flags.
   always_comb begin
      wr_ptr_d    = wr_ptr_q + PTR_W'(push0_c) + PTR_W'(push1_c);
      rd_ptr_d    = rd_ptr_q;
      order_d     = order_q;
      out_valid_d = pop_c;
      out_order_d = out_order_q;
      out_pkt_d   = out_pkt_q;
      halt_d      = halt_q | halt_hit_c;
      error_d     = error_q | reject_c;
      if (pop_c) begin
         rd_ptr_d    = rd_ptr_q + PTR_W'(1);
         out_pkt_d   = mem_q[rd_idx_c];
         out_order_d = order_q;
         order_d     = order_q + 64'd1;
      end
   end

   // Control and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         order_q     <= '0;
         out_valid_q <= 1'b0;
         out_order_q <= '0;
         out_pkt_q   <= '0;
         halt_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         order_q     <= order_d;
         out_valid_q <= out_valid_d;
         out_order_q <= out_order_d;
         out_pkt_q   <= out_pkt_d;
         halt_q      <= halt_d;
         error_q     <= error_d;
      end
   end

   // Storage writes; a lane pair may straddle the end of the buffer.
   always_ff @(posedge clk) begin
      if (push0_c) begin
         mem_q[wr_idx0_c] <= in_pkt0;
      end
      if (push1_c) begin
         mem_q[wr_idx1_c] <= in_pkt1;
      end
   end

   assign in_ready  = ready_c;
   assign occupancy = occ_c;
   assign out_valid = out_valid_q;
   assign out_order = out_order_q;
   assign out_pkt   = out_pkt_q;
   assign halt      = halt_q;
   assign error     = error_q;

endmodule

// File: tb/tb_rvfi_commit_sched.sv
// tb_rvfi_commit_sched: scoreboard bench for the RVFI commit scheduler.
module tb_rvfi_commit_sched;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned PKT_W = 311;
   localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

   logic             clk;
   logic             rst;
   logic [1:0]       in_valid;
   logic [PKT_W-1:0] in_pkt0;
   logic [PKT_W-1:0] in_pkt1;
   logic             in_ready;
   logic             out_valid;
   logic [63:0]      out_order;
   logic [PKT_W-1:0] out_pkt;
   logic [OCC_W-1:0] occupancy;
   logic             halt;
   logic             error;

   rvfi_commit_sched #(.DEPTH(DEPTH), .PKT_W(PKT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_pkt0   (in_pkt0),
      .in_pkt1   (in_pkt1),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_order (out_order),
      .out_pkt   (out_pkt),
      .occupancy (occupancy),
      .halt      (halt),
      .error     (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tot = 0;
   int n_bad = 0;

   // Scoreboard of {order, record} awaiting emission.
   logic [PKT_W+63:0] sb_q[$];
   // Halting flag of each record the reference model holds in its FIFO.
   bit                mq[$];
   bit                m_ov   = 1'b0;
   bit                m_oh   = 1'b0;
   bit                m_halt = 1'b0;
   bit                m_err  = 1'b0;
   logic [63:0]       ord    = '0;
   logic [PKT_W+63:0] sb_e;

   // Single comparison point: counts and reports a mismatch.
   task automatic chk(input string tag, input logic [PKT_W-1:0] got,
                      input logic [PKT_W-1:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit is_halt(input logic [PKT_W-1:0] p);
      logic [31:0] inst;
      logic [31:0] pcr;
      logic [31:0] pcw;
      inst = p[310:279];
      pcr  = p[167:136];
      pcw  = p[135:104];
      return (pcr == pcw) || (inst == 32'h0000_0063) || (inst == 32'h0000_006f);
   endfunction

   function automatic logic [PKT_W-1:0] make_pkt(input logic [31:0] inst,
                                                  input logic [31:0] pcr,
                                                  input logic [31:0] pcw);
      logic [31:0] r0, r1, r2, r3, r4, r5;
      r0 = $urandom(); r1 = $urandom(); r2 = $urandom();
      r3 = $urandom(); r4 = $urandom(); r5 = $urandom();
      return {inst, r0[4:0], r0[9:5], r1, r2, r0[14:10], r3,
              pcr, pcw, r4, r0[19:16], r0[23:20], r5, ~r4};
   endfunction

   // Ordinary non-halting record with random contents.
   function automatic logic [PKT_W-1:0] rnd_pkt();
      logic [31:0] r;
      logic [31:0] pc;
      r  = $urandom();
      pc = $urandom();
      pc[1:0] = 2'b00;
      return make_pkt({r[31:7], 7'h13}, pc, pc + 32'd4);
   endfunction

   function automatic bit m_ready();
      return !m_halt && (mq.size() <= int'(DEPTH) - 2);
   endfunction

   // One clock of stimulus: check pre-edge state, drive, advance model, check flags.
   task automatic drive(input logic [1:0] v, input logic [PKT_W-1:0] p0,
                        input logic [PKT_W-1:0] p1);
      bit rdy;
      bit pop;
      bit nh;
      rdy = m_ready();
      chk("in_ready", PKT_W'(in_ready), PKT_W'(rdy));
      chk("occupancy", PKT_W'(occupancy), PKT_W'(mq.size()));
      in_valid = v;
      in_pkt0  = p0;
      in_pkt1  = p1;
      nh = m_halt | (m_ov & m_oh);
      if ((v == 2'b10) || ((v != 2'b00) && !rdy)) m_err = 1'b1;
      pop  = (mq.size() > 0);
      m_ov = pop;
      if (pop) m_oh = mq.pop_front();
      if (rdy && v[0]) begin
         mq.push_back(is_halt(p0));
         sb_q.push_back({ord, p0});
         ord = ord + 64'd1;
      end
      if (rdy && (v == 2'b11)) begin
         mq.push_back(is_halt(p1));
         sb_q.push_back({ord, p1});
         ord = ord + 64'd1;
      end
      m_halt = nh;
      @(posedge clk);
      #1;
      chk("out_valid", PKT_W'(out_valid), PKT_W'(m_ov));
      chk("error", PKT_W'(error), PKT_W'(m_err));
      chk("halt", PKT_W'(halt), PKT_W'(m_halt));
      in_valid = 2'b00;
   endtask

   task automatic idle();
      drive(2'b00, '0, '0);
   endtask

   // Run idle cycles until the model has nothing left to emit.
   task automatic drain();
      for (int i = 0; i < 40 && (mq.size() > 0 || m_ov); i++) idle();
      idle();
      chk("drain_occ", PKT_W'(occupancy), '0);
      chk("drain_left", PKT_W'(sb_q.size()), '0);
   endtask

   // Reset pulse between clock edges; outputs must clear immediately.
   task automatic pulse_rst();
      chk("pre_rst_occ", PKT_W'(occupancy), PKT_W'(mq.size()));
      in_valid = 2'b00;
      #2 rst = 1'b1;
      #1;
      chk("rst_out_valid", PKT_W'(out_valid), '0);
      chk("rst_occupancy", PKT_W'(occupancy), '0);
      chk("rst_in_ready", PKT_W'(in_ready), PKT_W'(1));
      chk("rst_halt", PKT_W'(halt), '0);
      chk("rst_error", PKT_W'(error), '0);
      chk("rst_out_order", PKT_W'(out_order), '0);
      rst = 1'b0;
      mq.delete();
      sb_q.delete();
      ord    = '0;
      m_ov   = 1'b0;
      m_oh   = 1'b0;
      m_halt = 1'b0;
      m_err  = 1'b0;
      #1;
   endtask

   // Emission monitor: every valid output must match the scoreboard head.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_out", PKT_W'(out_valid), '0);
         end else begin
            sb_e = sb_q.pop_front();
            chk("out_order", PKT_W'(out_order), PKT_W'(sb_e[PKT_W+63:PKT_W]));
            chk("out_pkt", out_pkt, sb_e[PKT_W-1:0]);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [PKT_W-1:0] p;
      logic [PKT_W-1:0] q;
      rst      = 1'b0;
      in_valid = 2'b00;
      in_pkt0  = '0;
      in_pkt1  = '0;

      // Reset state
      #2 rst = 1'b1;
      #1;
      chk("init_out_valid", PKT_W'(out_valid), '0);
      chk("init_out_order", PKT_W'(out_order), '0);
      chk("init_out_pkt", out_pkt, '0);
      chk("init_occupancy", PKT_W'(occupancy), '0);
      chk("init_halt", PKT_W'(halt), '0);
      chk("init_error", PKT_W'(error), '0);
      chk("init_in_ready", PKT_W'(in_ready), PKT_W'(1));
      @(posedge clk);
      #1 rst = 1'b0;

      // Single commit
      p = make_pkt(32'h0000_0013, 32'h4000_0000, 32'h4000_0004);
      drive(2'b01, p, '0);
      drain();

      // Sustained dual commit, gated on readiness, including wrap-around
      for (int i = 0; i < 5; i++) begin
         if (m_ready()) drive(2'b11, rnd_pkt(), rnd_pkt());
         else idle();
      end
      for (int i = 0; i < 12; i++) begin
         if (m_ready()) drive(2'b11, rnd_pkt(), rnd_pkt());
         else idle();
      end
      for (int i = 0; i < 10 && m_ready(); i++) drive(2'b11, rnd_pkt(), rnd_pkt());

      // Overflow: pair offered while not ready is dropped and flags error
      chk("overflow_setup", PKT_W'(in_ready), '0);
      drive(2'b11, rnd_pkt(), rnd_pkt());
      drain();
      idle();

      // Illegal lane pattern with room available
      pulse_rst();
      drive(2'b10, rnd_pkt(), rnd_pkt());
      drain();

      // Halt: self-jump behind three queued records
      pulse_rst();
      drive(2'b11, rnd_pkt(), rnd_pkt());
      q = make_pkt(32'h0000_006f, 32'h4000_0010, 32'h4000_0010);
      drive(2'b11, rnd_pkt(), q);
      drain();
      drive(2'b01, rnd_pkt(), '0);
      idle();
      idle();

      // Async reset mid-stream with five buffered records
      pulse_rst();
      for (int i = 0; i < 4; i++) drive(2'b11, rnd_pkt(), rnd_pkt());
      chk("mid_occ", PKT_W'(occupancy), PKT_W'(5));
      pulse_rst();
      drive(2'b01, rnd_pkt(), '0);
      drain();

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
